// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state register plus combinational outputs from state, Opcode, Zero and MemReady.
// Optional MEM_HANDSHAKE_EN: when defined, MemReady stalls FETCH/MEM_READ/MEM_WRITE; otherwise memory is assumed always ready.
module multicycle_control #(
  parameter logic [5:0] JR_FUNCT = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Function,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JR        = 4'd12,
    S_IDLE      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_t state_q, state_d;
  logic   ready;

`ifdef MEM_HANDSHAKE_EN
  assign ready = MemReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = MemReady;
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign State = state_q;
  assign PCEn  = PCWrite | (PCWriteCond & Zero);

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    IllegalOp   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
        // IR and PC update only in the cycle the instruction word arrives
        IRWrite = ready;
        PCWrite = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 2'b11;
        case (Opcode)
          OP_RTYPE:       state_d = (Function == JR_FUNCT) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          default: begin
            IllegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        state_d = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
        state_d  = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (Opcode == OP_SLTI) ? 2'b10 : 2'b11;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand sequences for waits and async reset.
module tb_multicycle_control;

`ifdef MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic       clk, rst_n;
  logic [5:0] Opcode, Function;
  logic       Zero, MemReady;
  logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, RegWrite, MemtoReg, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  multicycle_control #(.JR_FUNCT(6'b001000)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Function(Function), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .IllegalOp(IllegalOp),
    .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] act_ctl;
  assign act_ctl = {PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst,
                    RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic [3:0]  exp_state;
    logic [17:0] exp_ctl;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   failed = 0;

  function automatic logic [17:0] c(input logic pcw, pcwc, pcen, iord, mr, mw, irw, rd, rw, m2r, asa,
                                    input logic [1:0] asb, aop, pcs, input logic ill);
    return {pcw, pcwc, pcen, iord, mr, mw, irw, rd, rw, m2r, asa, asb, aop, pcs, ill};
  endfunction

  function automatic vec_t mk(input logic [5:0] op, fn, input logic z, input logic [3:0] st,
                              input logic [17:0] ctl);
    vec_t v;
    v.op = op; v.fn = fn; v.zero = z; v.exp_state = st; v.exp_ctl = ctl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [17:0] C_FETCH, C_FWAIT, C_DEC, C_ILL, C_MADDR, C_MREAD, C_MWB, C_MWR, C_REX, C_RWB;
  logic [17:0] C_BRZ, C_BRN, C_J, C_JR, C_SLTI, C_IWB;
  int  lowcnt, cycles;
  bit  done;

  initial begin
    C_FETCH = c(1,0,1,0,1,0,1,0,0,0,0, 2'b01, 2'b11, 2'b00, 0);
    C_FWAIT = c(0,0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b11, 2'b00, 0);
    C_DEC   = c(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b11, 2'b00, 0);
    C_ILL   = c(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b11, 2'b00, 1);
    C_MADDR = c(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b11, 2'b00, 0);
    C_MREAD = c(0,0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
    C_MWB   = c(0,0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0);
    C_MWR   = c(0,0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
    C_REX   = c(0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 0);
    C_RWB   = c(0,0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 0);
    C_BRZ   = c(0,1,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0);
    C_BRN   = c(0,1,0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0);
    C_J     = c(1,0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0);
    C_JR    = c(1,0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b11, 0);
    C_SLTI  = c(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b10, 2'b00, 0);
    C_IWB   = c(0,0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 0);

    // add: 0,1,6,7
    vecs.push_back(mk(6'o00, 6'b100000, 0, 4'd0, C_FETCH));
    vecs.push_back(mk(6'o00, 6'b100000, 0, 4'd1, C_DEC));
    vecs.push_back(mk(6'o00, 6'b100000, 0, 4'd6, C_REX));
    vecs.push_back(mk(6'o00, 6'b100000, 0, 4'd7, C_RWB));
    // lw: 0,1,2,3,4
    vecs.push_back(mk(6'b100011, 6'd0, 0, 4'd0, C_FETCH));
    vecs.push_back(mk(6'b100011, 6'd0, 0, 4'd1, C_DEC));
    vecs.push_back(mk(6'b100011, 6'd0, 0, 4'd2, C_MADDR));
    vecs.push_back(mk(6'b100011, 6'd0, 0, 4'd3, C_MREAD));
    vecs.push_back(mk(6'b100011, 6'd0, 0, 4'd4, C_MWB));
    // sw: 0,1,2,5
    vecs.push_back(mk(6'b101011, 6'd0, 0, 4'd0, C_FETCH));
    vecs.push_back(mk(6'b101011, 6'd0, 0, 4'd1, C_DEC));
    vecs.push_back(mk(6'b101011, 6'd0, 0, 4'd2, C_MADDR));
    vecs.push_back(mk(6'b101011, 6'd0, 0, 4'd5, C_MWR));
    // beq taken then not taken
    vecs.push_back(mk(6'b000100, 6'd0, 1, 4'd0, C_FETCH));
    vecs.push_back(mk(6'b000100, 6'd0, 1, 4'd1, C_DEC));
    vecs.push_back(mk(6'b000100, 6'd0, 1, 4'd8, C_BRZ));
    vecs.push_back(mk(6'b000100, 6'd0, 0, 4'd0, C_FETCH));
    vecs.push_back(mk(6'b000100, 6'd0, 0, 4'd1, C_DEC));
    vecs.push_back(mk(6'b000100, 6'd0, 0, 4'd8, C_BRN));
    // j
    vecs.push_back(mk(6'b000010, 6'd0, 0, 4'd0, C_FETCH));
    vecs.push_back(mk(6'b000010, 6'd0, 0, 4'd1, C_DEC));
    vecs.push_back(mk(6'b000010, 6'd0, 0, 4'd9, C_J));
    // jr: 0,1,12
    vecs.push_back(mk(6'o00, 6'b001000, 0, 4'd0, C_FETCH));
    vecs.push_back(mk(6'o00, 6'b001000, 0, 4'd1, C_DEC));
    vecs.push_back(mk(6'o00, 6'b001000, 0, 4'd12, C_JR));
    // addi, slti
    vecs.push_back(mk(6'b001000, 6'd0, 0, 4'd0, C_FETCH));
    vecs.push_back(mk(6'b001000, 6'd0, 0, 4'd1, C_DEC));
    vecs.push_back(mk(6'b001000, 6'd0, 0, 4'd10, C_MADDR));
    vecs.push_back(mk(6'b001000, 6'd0, 0, 4'd11, C_IWB));
    vecs.push_back(mk(6'b001010, 6'd0, 0, 4'd0, C_FETCH));
    vecs.push_back(mk(6'b001010, 6'd0, 0, 4'd1, C_DEC));
    vecs.push_back(mk(6'b001010, 6'd0, 0, 4'd10, C_SLTI));
    vecs.push_back(mk(6'b001010, 6'd0, 0, 4'd11, C_IWB));
    // illegal opcode, pulse in DECODE
    vecs.push_back(mk(6'b111111, 6'd0, 0, 4'd0, C_FETCH));
    vecs.push_back(mk(6'b111111, 6'd0, 0, 4'd1, C_ILL));

    rst_n = 1'b1; Opcode = '0; Function = 6'b100000; Zero = 1'b0; MemReady = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_state", {28'd0, State}, 32'd15);
    chk("reset_ctl", {14'd0, act_ctl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_state", {28'd0, State}, 32'd15);
    chk("idle_ctl", {14'd0, act_ctl}, 32'd0);
    @(negedge clk);

    foreach (vecs[i]) begin
      Opcode = vecs[i].op; Function = vecs[i].fn; Zero = vecs[i].zero; MemReady = 1'b1;
      #1;
      chk($sformatf("vec%0d_state", i), {28'd0, State}, {28'd0, vecs[i].exp_state});
      chk($sformatf("vec%0d_ctl", i), {14'd0, act_ctl}, {14'd0, vecs[i].exp_ctl});
      @(negedge clk);
    end

    // FETCH with memory not ready; also confirms IllegalOp dropped after one cycle
    Opcode = 6'o00; Function = 6'b100000; Zero = 1'b0; MemReady = 1'b0;
    #1;
    chk("fetch_wait_state", {28'd0, State}, 32'd0);
    chk("fetch_wait_ctl", {14'd0, act_ctl}, {14'd0, HS ? C_FWAIT : C_FETCH});
    @(negedge clk);
    chk("fetch_wait_next", {28'd0, State}, HS ? 32'd0 : 32'd1);

    // lw with two not-ready cycles in MEM_READ
    MemReady = 1'b1;
    do_reset();
    Opcode = 6'b100011; lowcnt = 0; cycles = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (State == 4'd3 && lowcnt < 2) begin MemReady = 1'b0; lowcnt++; end
      else MemReady = 1'b1;
      #1;
      if (State == 4'd3) chk("lw_wait_iord_memread", {30'd0, IorD, MemRead}, 32'd3);
      @(negedge clk);
      cycles++;
      if (State == 4'd0) done = 1'b1;
    end
    chk("lw_returned", {31'd0, done}, 32'd1);
    chk("lw_cycles", cycles, HS ? 32'd7 : 32'd5);

    // async reset during MEM_WRITE
    MemReady = 1'b1;
    do_reset();
    Opcode = 6'b101011; done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      if (State == 4'd5) done = 1'b1;
      else @(negedge clk);
    end
    chk("sw_reached_memwrite", {31'd0, done}, 32'd1);
    MemReady = 1'b0;
    #1;
    chk("sw_memwrite_active", {31'd0, MemWrite}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_memwrite_drop", {31'd0, MemWrite}, 32'd0);
    chk("rst_state_idle", {28'd0, State}, 32'd15);
    chk("rst_ctl_zero", {14'd0, act_ctl}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
